// File: rtl/fifo_packet_writer.sv
// Packet-framing writer: streams bytes into a data FIFO and pushes each packet's
// length into a length FIFO, truncating at MAX_LEN. Optional stats: FIFO_WRITER_STATS_EN.
module fifo_packet_writer #(
  parameter int unsigned MAX_LEN = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       in_ready,
  output logic       data_wr_en,
  output logic [7:0] data_wr,
  input  logic       data_full,
  output logic       len_wr_en,
  output logic [7:0] len_wr,
  input  logic       len_full,
  output logic       busy,
  output logic       trunc_pulse
`ifdef FIFO_WRITER_STATS_EN
  ,
  output logic [15:0] pkt_count,
  output logic [15:0] trunc_count
`endif
);

  typedef enum logic [1:0] {IDLE, DATA, LEN, DROP} state_t;

  localparam logic [7:0] MAX_LEN8 = 8'(MAX_LEN);

  state_t     state;
  logic [7:0] cnt;
  logic       trunc;
  logic       accept;
  logic       write_beat;
  logic [7:0] cnt_next;
  logic       at_max;

  always_comb begin
    in_ready = 1'b0;
    case (state)
      IDLE, DATA: in_ready = !data_full;
      DROP:       in_ready = 1'b1;
      default:    in_ready = 1'b0;
    endcase
    accept     = in_valid && in_ready;
    write_beat = accept && (state == IDLE || state == DATA);
    // IDLE always starts a fresh packet, so the count restarts at 1 there
    cnt_next   = (state == IDLE) ? 8'd1 : cnt + 8'd1;
    at_max     = (cnt_next == MAX_LEN8);
  end

  assign data_wr_en = write_beat;
  assign data_wr    = in_data;
  assign len_wr_en  = (state == LEN) && !len_full;
  assign len_wr     = cnt;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      trunc       <= 1'b0;
      trunc_pulse <= 1'b0;
    end else begin
      trunc_pulse <= write_beat && !in_last && at_max;
      case (state)
        IDLE, DATA: begin
          if (write_beat) begin
            cnt <= cnt_next;
            if (in_last) begin
              state <= LEN;
            end else if (at_max) begin
              state <= LEN;
              trunc <= 1'b1;
            end else begin
              state <= DATA;
            end
          end
        end
        LEN: begin
          if (!len_full) begin
            cnt   <= '0;
            state <= trunc ? DROP : IDLE;
          end
        end
        DROP: begin
          if (accept && in_last) begin
            state <= IDLE;
            trunc <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FIFO_WRITER_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_count   <= '0;
      trunc_count <= '0;
    end else begin
      if (len_wr_en && pkt_count != '1)
        pkt_count <= pkt_count + 16'd1;
      if (trunc_pulse && trunc_count != '1)
        trunc_count <= trunc_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_packet_writer.sv
// Bench for fifo_packet_writer: two instances (MAX_LEN 255 and 4), directed
// cycle checks plus randomized packets scored against a packet-level model.
`timescale 1ns/1ps
module tb_fifo_packet_writer;

  logic       clk = 1'b0;
  logic       rst;
  logic       iv[2], il[2], rdy[2], dwe[2], lwe[2], bsy[2], tp[2], df[2], lf[2];
  logic [7:0] id[2], dw[2], lw[2];
`ifdef FIFO_WRITER_STATS_EN
  logic [15:0] pc[2], tcn[2];
`endif

  always #5 clk = ~clk;

  fifo_packet_writer u_max255 (
    .clk(clk), .reset(rst), .in_valid(iv[0]), .in_data(id[0]), .in_last(il[0]),
    .in_ready(rdy[0]), .data_wr_en(dwe[0]), .data_wr(dw[0]), .data_full(df[0]),
    .len_wr_en(lwe[0]), .len_wr(lw[0]), .len_full(lf[0]), .busy(bsy[0]),
    .trunc_pulse(tp[0])
`ifdef FIFO_WRITER_STATS_EN
    , .pkt_count(pc[0]), .trunc_count(tcn[0])
`endif
  );

  fifo_packet_writer #(.MAX_LEN(4)) u_max4 (
    .clk(clk), .reset(rst), .in_valid(iv[1]), .in_data(id[1]), .in_last(il[1]),
    .in_ready(rdy[1]), .data_wr_en(dwe[1]), .data_wr(dw[1]), .data_full(df[1]),
    .len_wr_en(lwe[1]), .len_wr(lw[1]), .len_full(lf[1]), .busy(bsy[1]),
    .trunc_pulse(tp[1])
`ifdef FIFO_WRITER_STATS_EN
    , .pkt_count(pc[1]), .trunc_count(tcn[1])
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Packet-level model: bytes beyond the limit vanish, length = min(N, limit)
  int         maxl[2] = '{255, 4};
  int         ne[2], nl[2], etr[2], cur[2], vb[2], vl[2];
  logic [7:0] exp_b[2][0:4095];
  logic [7:0] exp_l[2][0:1023];

  task automatic model_byte(input int k, input logic [7:0] d);
    if (cur[k] < maxl[k]) begin
      exp_b[k][ne[k]] = d;
      ne[k]++;
    end
    cur[k]++;
  endtask

  task automatic model_end(input int k);
    exp_l[k][nl[k]] = 8'((cur[k] < maxl[k]) ? cur[k] : maxl[k]);
    nl[k]++;
    if (cur[k] > maxl[k]) etr[k]++;
    cur[k] = 0;
  endtask

  // Monitor: logs every FIFO push and trunc pulse, flags writes into a full FIFO
  int         nb[2], ngl[2], ntr[2], viol[2];
  logic [7:0] got_b[2][0:4095];
  logic [7:0] got_l[2][0:1023];

  initial for (int k = 0; k < 2; k++) begin
    nb[k] = 0; ngl[k] = 0; ntr[k] = 0; viol[k] = 0;
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (dwe[k]) begin
        got_b[k][nb[k]] <= dw[k];
        nb[k] <= nb[k] + 1;
        if (df[k]) viol[k] <= viol[k] + 1;
      end
      if (lwe[k]) begin
        got_l[k][ngl[k]] <= lw[k];
        ngl[k] <= ngl[k] + 1;
        if (lf[k]) viol[k] <= viol[k] + 1;
      end
      if (tp[k]) ntr[k] <= ntr[k] + 1;
    end
  end

  task automatic verify();
    for (int k = 0; k < 2; k++) begin
      check("byte_count", nb[k], ne[k]);
      for (int i = vb[k]; i < ne[k] && i < nb[k]; i++)
        check("byte_value", int'(got_b[k][i]), int'(exp_b[k][i]));
      check("len_count", ngl[k], nl[k]);
      for (int i = vl[k]; i < nl[k] && i < ngl[k]; i++)
        check("len_value", int'(got_l[k][i]), int'(exp_l[k][i]));
      check("trunc_count_seen", ntr[k], etr[k]);
      check("write_while_full", viol[k], 0);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic rand_en = 1'b0;

  // Entered and left at posedge+1; holds the beat until it is accepted
  task automatic send_beat(input int k, input logic [7:0] d, input logic last);
    logic done;
    done  = 1'b0;
    iv[k] = 1'b1; id[k] = d; il[k] = last;
    for (int t = 0; t < 400 && !done; t++) begin
      if (rand_en) begin
        df[k] = ($urandom_range(0, 3) == 0);
        lf[k] = ($urandom_range(0, 3) == 0);
      end
      @(negedge clk);
      done = rdy[k];
      @(posedge clk);
      #1;
    end
    iv[k] = 1'b0; il[k] = 1'b0;
    if (!done) check("beat_timeout", 0, 1);
  endtask

  task automatic send_pkt(input int k, input int n);
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      d = 8'($urandom);
      send_beat(k, d, i == n - 1);
      model_byte(k, d);
    end
    model_end(k);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      iv[k] = 0; il[k] = 0; id[k] = '0; df[k] = 0; lf[k] = 0;
      ne[k] = 0; nl[k] = 0; etr[k] = 0; cur[k] = 0; vb[k] = 0; vl[k] = 0;
    end
    rst = 1'b1;
    #2;
    for (int k = 0; k < 2; k++) begin
      check("rst_busy", bsy[k], 0);
      check("rst_data_wr_en", dwe[k], 0);
      check("rst_len_wr_en", lwe[k], 0);
      check("rst_len_wr", int'(lw[k]), 0);
      check("rst_trunc_pulse", tp[k], 0);
      check("rst_in_ready", rdy[k], 1);
`ifdef FIFO_WRITER_STATS_EN
      check("rst_pkt_count", int'(pc[k]), 0);
      check("rst_trunc_count", int'(tcn[k]), 0);
`endif
    end
    df[0] = 1'b1; id[0] = 8'h3C;
    #1;
    check("rst_in_ready_full", rdy[0], 0);
    check("rst_data_wr", int'(dw[0]), 8'h3C);
    df[0] = 1'b0;
    cyc(); cyc();
    rst = 1'b0;

    // Three-byte packet
    cyc(); iv[0] = 1; id[0] = 8'h11; il[0] = 0; #1;
    check("p1_wr11_en", dwe[0], 1); check("p1_wr11", int'(dw[0]), 8'h11);
    model_byte(0, 8'h11);
    cyc(); id[0] = 8'h22; #1;
    check("p1_wr22_en", dwe[0], 1); check("p1_wr22", int'(dw[0]), 8'h22);
    model_byte(0, 8'h22);
    cyc(); id[0] = 8'h33; il[0] = 1; #1;
    check("p1_wr33_en", dwe[0], 1); check("p1_wr33", int'(dw[0]), 8'h33);
    model_byte(0, 8'h33); model_end(0);
    cyc(); iv[0] = 0; il[0] = 0; #1;
    check("p1_len_en", lwe[0], 1); check("p1_len", int'(lw[0]), 3);
    check("p1_len_ready", rdy[0], 0);
    cyc(); #1;
    check("p1_idle", bsy[0], 0); check("p1_len_once", lwe[0], 0);

    // Back-to-back one-byte packets: 4 cycles total
    cyc(); iv[0] = 1; id[0] = 8'hA0; il[0] = 1; #1;
    check("p2_wrA0", int'(dw[0]), 8'hA0); check("p2_wrA0_en", dwe[0], 1);
    model_byte(0, 8'hA0); model_end(0);
    cyc(); id[0] = 8'hA1; #1;
    check("p2_len1_en", lwe[0], 1); check("p2_len1", int'(lw[0]), 1);
    check("p2_stall_ready", rdy[0], 0); check("p2_stall_wr", dwe[0], 0);
    cyc(); #1;
    check("p2_wrA1_en", dwe[0], 1); check("p2_wrA1", int'(dw[0]), 8'hA1);
    model_byte(0, 8'hA1); model_end(0);
    cyc(); iv[0] = 0; il[0] = 0; #1;
    check("p2_len2_en", lwe[0], 1); check("p2_len2", int'(lw[0]), 1);
    cyc(); #1;
    check("p2_idle", bsy[0], 0);

    // Truncation at MAX_LEN=4: seven bytes
    for (int i = 1; i <= 4; i++) begin
      cyc(); iv[1] = 1; id[1] = 8'(i); il[1] = 0; #1;
      check("tr_wr_en", dwe[1], 1); check("tr_wr", int'(dw[1]), i);
      model_byte(1, 8'(i));
    end
    cyc(); id[1] = 8'h05; #1;
    check("tr_len_en", lwe[1], 1); check("tr_len", int'(lw[1]), 4);
    check("tr_pulse", tp[1], 1); check("tr_len_ready", rdy[1], 0);
    for (int i = 5; i <= 7; i++) begin
      cyc(); id[1] = 8'(i); il[1] = (i == 7); #1;
      check("tr_drop_ready", rdy[1], 1); check("tr_drop_wr", dwe[1], 0);
      check("tr_drop_pulse", tp[1], 0); check("tr_drop_busy", bsy[1], 1);
      model_byte(1, 8'(i));
    end
    model_end(1);
    cyc(); iv[1] = 0; il[1] = 0; #1;
    check("tr_idle", bsy[1], 0);

    // Exact boundary at MAX_LEN=4
    for (int i = 1; i <= 4; i++) begin
      cyc(); iv[1] = 1; id[1] = 8'(8'h10 + i); il[1] = (i == 4); #1;
      check("bd_wr_en", dwe[1], 1);
      model_byte(1, 8'(8'h10 + i));
    end
    model_end(1);
    cyc(); iv[1] = 0; il[1] = 0; #1;
    check("bd_len_en", lwe[1], 1); check("bd_len", int'(lw[1]), 4);
    check("bd_no_pulse", tp[1], 0);
    cyc(); #1;
    check("bd_no_drop", bsy[1], 0); check("bd_no_pulse2", tp[1], 0);

    // Backpressure on both FIFOs
    cyc(); iv[0] = 1; id[0] = 8'hB1; #1; check("bp_b1", dwe[0], 1); model_byte(0, 8'hB1);
    cyc(); id[0] = 8'hB2; #1; check("bp_b2", dwe[0], 1); model_byte(0, 8'hB2);
    cyc(); id[0] = 8'hB3; df[0] = 1; #1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) cyc();
      #1; check("bp_full_ready", rdy[0], 0); check("bp_full_wr", dwe[0], 0);
    end
    cyc(); df[0] = 0; #1; check("bp_b3", dwe[0], 1); check("bp_b3_val", int'(dw[0]), 8'hB3);
    model_byte(0, 8'hB3);
    cyc(); id[0] = 8'hB4; #1; check("bp_b4", dwe[0], 1); model_byte(0, 8'hB4);
    cyc(); id[0] = 8'hB5; il[0] = 1; #1; check("bp_b5", dwe[0], 1); model_byte(0, 8'hB5);
    model_end(0);
    cyc(); iv[0] = 0; il[0] = 0; lf[0] = 1; #1;
    check("bp_lfull_en", lwe[0], 0); check("bp_lfull_ready", rdy[0], 0); check("bp_lfull_busy", bsy[0], 1);
    cyc(); #1;
    check("bp_lfull_en2", lwe[0], 0); check("bp_lfull_ready2", rdy[0], 0);
    cyc(); lf[0] = 0; #1;
    check("bp_len_en", lwe[0], 1); check("bp_len", int'(lw[0]), 5);
    cyc(); #1; check("bp_idle", bsy[0], 0);
    cyc();
    verify();

    // Randomized packets with random FIFO stalls
    rand_en = 1'b1;
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < 30; p++)
        send_pkt(k, int'($urandom_range(1, 7)));
    send_pkt(0, 255);
    send_pkt(0, 256);
    send_pkt(1, 1);
    rand_en = 1'b0;
    for (int k = 0; k < 2; k++) begin df[k] = 0; lf[k] = 0; end
    repeat (20) cyc();
    verify();
`ifdef FIFO_WRITER_STATS_EN
    for (int k = 0; k < 2; k++) begin
      check("stat_pkt_count", int'(pc[k]), nl[k]);
      check("stat_trunc_count", int'(tcn[k]), etr[k]);
    end
`endif

    // Reset mid-packet aborts without a length write
    send_beat(0, 8'hC1, 1'b0);
    send_beat(0, 8'hC2, 1'b0);
    rst = 1'b1; #1;
    check("mid_rst_busy", bsy[0], 0); check("mid_rst_len_en", lwe[0], 0);
    cyc(); rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      ne[k] = nb[k]; vb[k] = nb[k]; vl[k] = ngl[k]; cur[k] = 0;
    end
    send_beat(0, 8'h5A, 1'b1);
    model_byte(0, 8'h5A); model_end(0);
    check("mid_rst_len_en2", lwe[0], 1); check("mid_rst_len", int'(lw[0]), 1);
    cyc(); #1;
`ifdef FIFO_WRITER_STATS_EN
    check("mid_rst_pkt_count", int'(pc[0]), 1);
`endif
    repeat (3) cyc();
    verify();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
